// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory: grants P or L,
// issues one memory cycle, then pulses the owner's Ack with captured read data.
module dmem_arbiter #(
  parameter int AddrWidth   = 8,
  parameter int StarveLimit = 4
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Req_P,
  input  logic        Req_L,
  input  logic        Wr_P,
  input  logic        Wr_L,
  input  logic [31:0] Addr_P,
  input  logic [31:0] Addr_L,
  input  logic [31:0] WData_P,
  input  logic [31:0] WData_L,
  output logic        Ack_P,
  output logic        Ack_L,
  output logic [31:0] RData_P,
  output logic [31:0] RData_L,
  output logic        Err_P,
  output logic        Err_L,
  output logic        Stall_P,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);

  localparam logic [3:0] STARVE_MAX = 4'(StarveLimit);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t      state_q;
  logic        owner_l_q;
  logic        wr_q;
  logic        oor_q;
  logic [3:0]  starve_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [31:0] address_q;
  logic [31:0] write_data_q;
  logic        ack_p_q;
  logic        ack_l_q;
  logic        err_p_q;
  logic        err_l_q;
  logic [31:0] rdata_p_q;
  logic [31:0] rdata_l_q;

  logic        grant_l_d;
  logic        sel_wr_d;
  logic        sel_oor_d;
  logic [31:0] sel_addr_d;
  logic [31:0] sel_wdata_d;
  logic [31:0] rdata_d;
  logic [3:0]  starve_d;

  always_comb begin
    // L wins when alone, or when P has had its run of StarveLimit grants
    grant_l_d   = Req_L & (~Req_P | (starve_q == STARVE_MAX));
    sel_wr_d    = grant_l_d ? Wr_L    : Wr_P;
    sel_addr_d  = grant_l_d ? Addr_L  : Addr_P;
    sel_wdata_d = grant_l_d ? WData_L : WData_P;
    sel_oor_d   = (sel_addr_d >> AddrWidth) != 32'd0;
    if (grant_l_d || !Req_L) begin
      starve_d = 4'd0;
    end else if (starve_q < STARVE_MAX) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
    rdata_d = (!wr_q && !oor_q) ? ReadData : 32'd0;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= IDLE;
      owner_l_q    <= 1'b0;
      wr_q         <= 1'b0;
      oor_q        <= 1'b0;
      starve_q     <= 4'd0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      address_q    <= 32'd0;
      write_data_q <= 32'd0;
      ack_p_q      <= 1'b0;
      ack_l_q      <= 1'b0;
      err_p_q      <= 1'b0;
      err_l_q      <= 1'b0;
      rdata_p_q    <= 32'd0;
      rdata_l_q    <= 32'd0;
    end else begin
      // Memory strobes and Acks are single-cycle pulses
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      address_q    <= 32'd0;
      write_data_q <= 32'd0;
      ack_p_q      <= 1'b0;
      ack_l_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Req_P || Req_L) begin
            owner_l_q    <= grant_l_d;
            wr_q         <= sel_wr_d;
            oor_q        <= sel_oor_d;
            starve_q     <= starve_d;
            mem_read_q   <= ~sel_wr_d & ~sel_oor_d;
            mem_write_q  <= sel_wr_d & ~sel_oor_d;
            address_q    <= sel_addr_d;
            write_data_q <= sel_wdata_d;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          if (owner_l_q) begin
            rdata_l_q <= rdata_d;
            err_l_q   <= oor_q;
            ack_l_q   <= 1'b1;
          end else begin
            rdata_p_q <= rdata_d;
            err_p_q   <= oor_q;
            ack_p_q   <= 1'b1;
          end
          state_q <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Ack_P     = ack_p_q;
  assign Ack_L     = ack_l_q;
  assign RData_P   = rdata_p_q;
  assign RData_L   = rdata_l_q;
  assign Err_P     = err_p_q;
  assign Err_L     = err_l_q;
  assign Stall_P   = Req_P & ~ack_p_q;
  assign MemRead   = mem_read_q;
  assign MemWrite  = mem_write_q;
  assign Address   = address_q;
  assign WriteData = write_data_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: falling-edge memory, transaction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_dmem_arbiter;
  localparam int LIMIT = 4;

  logic        Clk, Rst_n;
  logic        Req_P, Req_L, Wr_P, Wr_L;
  logic [31:0] Addr_P, Addr_L, WData_P, WData_L;
  logic        Ack_P, Ack_L, Err_P, Err_L, Stall_P, MemRead, MemWrite;
  logic [31:0] RData_P, RData_L, Address, WriteData, ReadData;

  int checks = 0, errors = 0, cyc = 0;
  int mem_rd_cnt = 0, mem_wr_cnt = 0, stall_cnt = 0, ackl_cnt = 0;
  logic [31:0] env_mem [256];
  logic [31:0] ref_mem [256];
  int grant_log [$];

  dmem_arbiter #(.AddrWidth(8), .StarveLimit(LIMIT)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Req_P(Req_P), .Req_L(Req_L), .Wr_P(Wr_P), .Wr_L(Wr_L),
    .Addr_P(Addr_P), .Addr_L(Addr_L), .WData_P(WData_P), .WData_L(WData_L),
    .Ack_P(Ack_P), .Ack_L(Ack_L), .RData_P(RData_P), .RData_L(RData_L),
    .Err_P(Err_P), .Err_L(Err_L), .Stall_P(Stall_P),
    .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
    .WriteData(WriteData), .ReadData(ReadData)
  );

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory environment: acts on the falling edge
  initial ReadData = 32'd0;
  always @(negedge Clk) begin
    if (MemWrite) begin
      env_mem[Address[7:0]] <= WriteData;
      mem_wr_cnt++;
    end
    if (MemRead) begin
      ReadData <= env_mem[Address[7:0]];
      mem_rd_cnt++;
    end
    if (Stall_P) stall_cnt++;
    if (Ack_L) ackl_cnt++;
  end

  // Reference model: one transaction occupies grant / issue / respond cycles
  int          m_phase = 0, m_starve = 0;
  bit          m_l = 0, m_wr = 0, m_gl, m_inr;
  logic [31:0] m_addr = 0, m_wdata = 0, m_rd;
  logic [31:0] e_rdp = 0, e_rdl = 0;
  bit          e_errp = 0, e_errl = 0;
  bit          e_issue, e_ackp, e_ackl;

  always @(posedge Clk) begin
    cyc++;
    if (!Rst_n) begin
      m_phase = 0; m_starve = 0; m_l = 0; m_wr = 0; m_addr = 0; m_wdata = 0;
      e_rdp = 0; e_rdl = 0; e_errp = 0; e_errl = 0;
    end else begin
      case (m_phase)
        0: if (Req_P || Req_L) begin
          m_gl     = Req_L && (!Req_P || m_starve == LIMIT);
          m_starve = (m_gl || !Req_L) ? 0 : ((m_starve < LIMIT) ? m_starve + 1 : LIMIT);
          m_l      = m_gl;
          m_wr     = m_gl ? Wr_L : Wr_P;
          m_addr   = m_gl ? Addr_L : Addr_P;
          m_wdata  = m_gl ? WData_L : WData_P;
          m_phase  = 1;
        end
        1: begin
          m_inr = m_addr < 256;
          m_rd  = 0;
          if (m_inr && m_wr) ref_mem[m_addr[7:0]] = m_wdata;
          if (m_inr && !m_wr) m_rd = ref_mem[m_addr[7:0]];
          if (m_l) begin e_rdl = m_rd; e_errl = !m_inr; end
          else begin e_rdp = m_rd; e_errp = !m_inr; end
          m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
    #1;
    e_issue = (m_phase == 1);
    e_ackp  = (m_phase == 2) && !m_l;
    e_ackl  = (m_phase == 2) && m_l;
    chk("MemRead",   MemRead,   e_issue && !m_wr && m_addr < 256);
    chk("MemWrite",  MemWrite,  e_issue && m_wr && m_addr < 256);
    chk("Address",   Address,   e_issue ? m_addr : 32'd0);
    chk("WriteData", WriteData, e_issue ? m_wdata : 32'd0);
    chk("Ack_P",     Ack_P,     e_ackp);
    chk("Ack_L",     Ack_L,     e_ackl);
    chk("Stall_P",   Stall_P,   Req_P && !e_ackp);
    chk("RData_P",   RData_P,   e_rdp);
    chk("RData_L",   RData_L,   e_rdl);
    chk("Err_P",     Err_P,     e_errp);
    chk("Err_L",     Err_L,     e_errl);
  end

  // Called at posedge+2 (or aligns there); returns at posedge+2 of the Ack cycle
  task automatic txn(input bit is_l, input bit align, input bit wr,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err, output int lat);
    int start;
    bit got;
    got = 0; rdata = 0; err = 0; lat = -1;
    if (align) begin
      @(posedge Clk);
      #2;
    end
    if (is_l) begin Req_L = 1; Wr_L = wr; Addr_L = addr; WData_L = wdata; end
    else      begin Req_P = 1; Wr_P = wr; Addr_P = addr; WData_P = wdata; end
    start = cyc;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge Clk);
      #1;
      if (is_l ? Ack_L : Ack_P) begin
        got   = 1;
        lat   = cyc - start;
        rdata = is_l ? RData_L : RData_P;
        err   = is_l ? Err_L : Err_P;
        grant_log.push_back(is_l ? 1 : 0);
      end
    end
    #1;
    if (is_l) Req_L = 0; else Req_P = 0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout port=%0d: no Ack within 60 cycles", is_l);
    end
  endtask

  logic [31:0] rd_p, rd_l;
  logic        er_p, er_l;
  int          lat_p, lat_l, c0, c1;
  int          exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  initial begin
    Rst_n = 0;
    Req_P = 0; Req_L = 0; Wr_P = 0; Wr_L = 0;
    Addr_P = 0; Addr_L = 0; WData_P = 0; WData_L = 0;
    for (int i = 0; i < 256; i++) env_mem[i] = 32'(i + 4);
    env_mem[0] = 32'd15; env_mem[1] = 32'd8; env_mem[246] = 32'd250;
    for (int i = 0; i < 256; i++) ref_mem[i] = env_mem[i];

    repeat (3) @(posedge Clk);
    #1;
    chk("reset_Ack_P", Ack_P, 0);
    chk("reset_MemRead", MemRead, 0);
    chk("reset_Address", Address, 0);
    chk("reset_RData_L", RData_L, 0);
    @(negedge Clk) Rst_n = 1;
    @(posedge Clk);
    #2;

    // P write then read back
    c0 = mem_wr_cnt;
    txn(0, 1, 1, 32'd18, 32'h2C, rd_p, er_p, lat_p);
    $display("txn P write addr 18 data 0000002c latency %0d", lat_p);
    chk("t1_wr_latency", lat_p, 2);
    chk("t1_wr_pulses", mem_wr_cnt - c0, 1);
    txn(0, 1, 0, 32'd18, 32'd0, rd_p, er_p, lat_p);
    $display("txn P read addr 18 data %h err %0d latency %0d", rd_p, er_p, lat_p);
    chk("t1_rd_data", rd_p, 32'h2C);
    chk("t1_rd_err", er_p, 0);
    chk("t1_rd_latency", lat_p, 2);

    // Simultaneous requests: P first, L three cycles later
    fork
      txn(0, 1, 0, 32'd1, 32'd0, rd_p, er_p, lat_p);
      txn(1, 1, 0, 32'd0, 32'd0, rd_l, er_l, lat_l);
    join
    $display("txn P read addr 1 data %h / L read addr 0 data %h, Ack gap %0d", rd_p, rd_l, lat_l - lat_p);
    chk("sim_rdata_p", rd_p, 32'd8);
    chk("sim_rdata_l", rd_l, 32'd15);
    chk("sim_ack_gap", lat_l - lat_p, 3);

    // Starvation: 8 back-to-back P reads against 2 L reads
    grant_log.delete();
    fork
      begin
        logic [31:0] r; logic e; int l;
        for (int i = 0; i < 8; i++) txn(0, i == 0, 0, 32'(i + 2), 32'd0, r, e, l);
      end
      begin
        logic [31:0] r; logic e; int l;
        for (int i = 0; i < 2; i++) txn(1, i == 0, 0, 32'(i + 100), 32'd0, r, e, l);
      end
    join
    $display("txn starvation round: %0d grants", grant_log.size());
    chk("starve_count", grant_log.size(), 10);
    for (int i = 0; i < 10 && i < grant_log.size(); i++)
      chk($sformatf("starve_order[%0d]", i), grant_log[i], exp_order[i]);

    // Out of range: L read 0x100, P write above the range
    c0 = mem_rd_cnt; c1 = mem_wr_cnt;
    txn(1, 1, 0, 32'h100, 32'd0, rd_l, er_l, lat_l);
    $display("txn L read addr 00000100 data %h err %0d", rd_l, er_l);
    chk("oor_err", er_l, 1);
    chk("oor_rdata", rd_l, 0);
    txn(0, 1, 1, 32'h1000_0012, 32'hDEAD, rd_p, er_p, lat_p);
    $display("txn P write addr 10000012 err %0d", er_p);
    chk("oor_err_p", er_p, 1);
    chk("oor_no_read", mem_rd_cnt - c0, 0);
    chk("oor_no_write", mem_wr_cnt - c1, 0);
    chk("oor_mem0", env_mem[0], 32'd15);
    chk("oor_mem18", env_mem[18], 32'h2C);

    // Top in-range word
    txn(0, 1, 1, 32'd255, 32'hA5, rd_p, er_p, lat_p);
    txn(0, 1, 0, 32'd255, 32'd0, rd_p, er_p, lat_p);
    $display("txn P read addr 255 data %h err %0d", rd_p, er_p);
    chk("edge_rdata", rd_p, 32'hA5);
    chk("edge_err", er_p, 0);

    // Stall window for a single P read
    c0 = stall_cnt; c1 = mem_rd_cnt;
    txn(0, 1, 0, 32'd18, 32'd0, rd_p, er_p, lat_p);
    $display("txn P read addr 18 stall cycles %0d", stall_cnt - c0);
    chk("stall_cycles", stall_cnt - c0, 2);
    chk("stall_reads", mem_rd_cnt - c1, 1);

    // Reset in ISSUE before the falling edge: write must not commit
    c0 = ackl_cnt;
    @(posedge Clk);
    #2;
    Req_L = 1; Wr_L = 1; Addr_L = 32'd246; WData_L = 32'd5;
    @(posedge Clk);
    #3;
    Rst_n = 0;
    #1;
    chk("rst_MemWrite", MemWrite, 0);
    chk("rst_Address", Address, 0);
    chk("rst_WriteData", WriteData, 0);
    chk("rst_Ack_L", Ack_L, 0);
    Req_L = 0;
    repeat (2) @(posedge Clk);
    @(negedge Clk) Rst_n = 1;
    $display("txn L write addr 246 aborted by reset, Ack_L pulses %0d", ackl_cnt - c0);
    chk("rst_no_ack", ackl_cnt - c0, 0);
    chk("rst_mem246", env_mem[246], 32'd250);
    @(posedge Clk);
    #2;
    txn(1, 0, 0, 32'd246, 32'd0, rd_l, er_l, lat_l);
    $display("txn L read addr 246 data %h latency %0d", rd_l, lat_l);
    chk("rst_readback", rd_l, 32'd250);
    chk("rst_first_grant", lat_l, 2);

    repeat (3) @(posedge Clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
